// File: rtl/chk9_pkg.sv
// Shared types for the checker9 response logger: FSM output width, RLE state
// encoding and the default-width trace record.
package chk9_pkg;

  localparam int unsigned Y_W       = 11;
  localparam int unsigned REC_RUN_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [Y_W-1:0]       word;
    logic [REC_RUN_W-1:0] run;
  } rec_t;

endpackage

// File: rtl/chk9_rec_fifo.sv
// Synchronous record FIFO with a registered head word, full/empty detection
// and simultaneous push/pop; a push while full is ignored unless popping.
module chk9_rec_fifo #(
  parameter int unsigned W     = 19,
  parameter int unsigned DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         valid,
  output logic [W-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;
  logic [AW:0]  wptr_n, rptr_n;
  logic         push_ok;

  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign push_ok = push && (!full || pop);
  assign rptr_n  = rptr + (AW+1)'(pop);
  assign wptr_n  = wptr + (AW+1)'(push_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= din;
  end

  // The head is preloaded for the next cycle; when the next head slot is the
  // one being written right now, it bypasses the memory and takes din.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      valid <= 1'b0;
      head  <= '0;
    end else begin
      wptr  <= wptr_n;
      rptr  <= rptr_n;
      valid <= (rptr_n != wptr_n);
      if (rptr_n != wptr_n) begin
        if (push_ok && (rptr_n == wptr)) head <= din;
        else                             head <= mem[rptr_n[AW-1:0]];
      end
    end
  end

endmodule

// File: rtl/chk9_resp_rle_logger.sv
// Run-length encodes the checker9 FSM output word into {word, run} records and
// buffers them for a valid/ready consumer, counting records lost to overflow.
module chk9_resp_rle_logger
  import chk9_pkg::*;
#(
  parameter int unsigned RUN_W  = REC_RUN_W,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DROP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic [Y_W-1:0]    y_in,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [Y_W-1:0]    out_word,
  output logic [RUN_W-1:0]  out_run,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int unsigned REC_W = Y_W + RUN_W;

  state_t               state;
  logic [Y_W-1:0]       cur_word;
  logic [RUN_W-1:0]     run;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 drop;
  logic [REC_W-1:0]     head;

  assign pop  = out_valid && out_ready;
  assign drop = push && full && !pop;

  always_comb begin
    push = 1'b0;
    if (flush)
      push = (state == RUN);
    else if (en && state == RUN && (y_in != cur_word || run == '1))
      push = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cur_word <= '0;
      run      <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else if (en) begin
      if (state == IDLE || y_in != cur_word) begin
        state    <= RUN;
        cur_word <= y_in;
        run      <= RUN_W'(1);
      end else if (run != '1) begin
        run <= run + RUN_W'(1);
      end else begin
        run <= RUN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

  chk9_rec_fifo #(
    .W     (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({cur_word, run}),
    .pop   (pop),
    .full  (full),
    .valid (out_valid),
    .head  (head)
  );

  assign out_word = head[REC_W-1:RUN_W];
  assign out_run  = head[RUN_W-1:0];

endmodule

// File: tb/tb_chk9_resp_rle_logger.sv
// Directed bench for the checker9 RLE logger with hand-computed expectations.
module tb_chk9_resp_rle_logger;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        flush;
  logic [10:0] y_in;
  logic        out_ready;
  logic        out_valid;
  logic [10:0] out_word;
  logic [7:0]  out_run;
  logic        overflow;
  logic [15:0] drop_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  chk9_resp_rle_logger #(
    .RUN_W  (8),
    .DEPTH  (8),
    .DROP_W (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .flush     (flush),
    .y_in      (y_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_word  (out_word),
    .out_run   (out_run),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [10:0] w, input logic [7:0] r);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_word"}, 32'(out_word), 32'(w));
    check({tag, "_run"}, 32'(out_run), 32'(r));
  endtask

  logic [10:0] exp_words [8];

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0; y_in = '0; out_ready = 1'b0;
    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_word", 32'(out_word), 32'd0);
    check("rst_run", 32'(out_run), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    rst = 1'b0;
    step();

    // T2: three samples of 0x048, then 0x180 closes the run
    en = 1'b1; y_in = 11'h048;
    repeat (3) step();
    check("t2_open_novalid", 32'(out_valid), 32'd0);
    y_in = 11'h180;
    step();
    check_head("t2_rec0", 11'h048, 8'd3);
    en = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    check_head("t2_head_held", 11'h048, 8'd3);
    out_ready = 1'b1;
    step();
    check_head("t2_rec1", 11'h180, 8'd1);
    step();
    check("t2_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // T3: 300 identical samples split at the 255 ceiling
    en = 1'b1; y_in = 11'h100;
    repeat (300) step();
    check_head("t3_rec0", 11'h100, 8'd255);
    en = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0; out_ready = 1'b1;
    step();
    check_head("t3_rec1", 11'h100, 8'd45);
    step();
    check("t3_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // T6: gaps in en do not close or extend the run; flush drops its sample
    en = 1'b1; y_in = 11'h055; step();
    en = 1'b0; y_in = 11'h3ff; step(); step();
    en = 1'b1; y_in = 11'h055; step();
    check("t6_open_novalid", 32'(out_valid), 32'd0);
    flush = 1'b1; y_in = 11'h0aa; step();
    flush = 1'b0; en = 1'b0;
    check_head("t6_rec", 11'h055, 8'd2);
    out_ready = 1'b1; step();
    check("t6_single_rec", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    en = 1'b1; y_in = 11'h0ab; step();
    en = 1'b0; step();
    check("t6_flushed_idle", 32'(out_valid), 32'd0);
    flush = 1'b1; step();
    flush = 1'b0;
    check_head("t6_new_run", 11'h0ab, 8'd1);
    out_ready = 1'b1; step();
    out_ready = 1'b0;

    // T4: 10 distinct words with no consumer -> 9 records, 9th dropped
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      y_in = 11'h010 + 11'(i);
      step();
    end
    check("t4_ovf", 32'(overflow), 32'd1);
    check("t4_drop", 32'(drop_cnt), 32'd1);
    check_head("t4_head", 11'h010, 8'd1);

    // T5: full FIFO, pop and push on the same edge -> no drop
    out_ready = 1'b1; y_in = 11'h01a;
    step();
    en = 1'b0;
    check("t5_drop", 32'(drop_cnt), 32'd1);
    for (int i = 0; i < 7; i++) exp_words[i] = 11'h011 + 11'(i);
    exp_words[7] = 11'h019;
    for (int i = 0; i < 8; i++) begin
      check_head($sformatf("t5_drain%0d", i), exp_words[i], 8'd1);
      step();
    end
    check("t5_empty", 32'(out_valid), 32'd0);
    check("t5_ovf_sticky", 32'(overflow), 32'd1);

    // T1: async reset mid-stream with records buffered and a run open
    out_ready = 1'b0; en = 1'b1; y_in = 11'h005;
    step();
    y_in = 11'h006; step(); step();
    check("t1_pre_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t1_valid", 32'(out_valid), 32'd0);
    check("t1_word", 32'(out_word), 32'd0);
    check("t1_run", 32'(out_run), 32'd0);
    check("t1_ovf", 32'(overflow), 32'd0);
    check("t1_drop", 32'(drop_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    y_in = 11'h003;
    step(); step();
    check("t1_no_rec_yet", 32'(out_valid), 32'd0);
    y_in = 11'h004; step();
    check_head("t1_new_rec", 11'h003, 8'd2);
    en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
